// File: rtl/fetch_sequencer_if.sv
// Fetch-to-execute handshake: registered instruction word out,
// acceptance strobe and branch redirect request back.
interface fetch_sequencer_if;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  br_op;
   logic [15:0] br_target;

   modport master (
      output instr, instr_valid,
      input  instr_ready, br_op, br_target
   );

   modport slave (
      input  instr, instr_valid,
      output instr_ready, br_op, br_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the PC and sync ROM, holds the
// fetched word for execute, and owns a small return-address stack.
module fetch_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int          STACK_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        pc_value,
   output logic [15:0]        pc_target,
   output logic               pc_load,
   output logic               pc_ce,
   output logic [15:0]        mem_addr,
   output logic               mem_en,
   input  logic [15:0]        mem_data,
   fetch_sequencer_if.master  fetch,
   input  logic               halt,
   output logic               stack_err
);
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      INIT, REQ, WAIT, HOLD, HALTED
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      instr_q;
   logic             valid_q;
   logic             err_q;
   logic [SPW-1:0]   sp_q;
   logic [15:0]      stack_q [STACK_DEPTH];
   logic             push, pop;
   logic             full, empty;
   logic [IW-1:0]    wr_idx, rd_idx;
   logic             accept;

   assign full   = (sp_q == SPW'(STACK_DEPTH));
   assign empty  = (sp_q == '0);
   assign wr_idx = sp_q[IW-1:0];
   assign rd_idx = IW'(sp_q - 1'b1);
   assign accept = (state_q == HOLD) && fetch.instr_ready;

   assign mem_addr          = pc_value;
   assign fetch.instr       = instr_q;
   assign fetch.instr_valid = valid_q;
   assign stack_err         = err_q;

   always_comb begin
      state_d   = state_q;
      pc_target = fetch.br_target;
      pc_load   = 1'b0;
      pc_ce     = 1'b0;
      mem_en    = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      unique case (state_q)
         INIT: begin
            pc_ce     = 1'b1;
            pc_load   = 1'b1;
            pc_target = RESET_VECTOR;
            state_d   = halt ? HALTED : REQ;
         end
         REQ: begin
            mem_en  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            pc_ce   = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (accept) begin
               state_d = halt ? HALTED : REQ;
               unique case (fetch.br_op)
                  2'b01: begin
                     pc_ce   = 1'b1;
                     pc_load = 1'b1;
                  end
                  2'b10: begin
                     pc_ce   = 1'b1;
                     pc_load = 1'b1;
                     push    = 1'b1;
                  end
                  2'b11: begin
                     pc_ce     = 1'b1;
                     pc_load   = 1'b1;
                     pop       = 1'b1;
                     pc_target = empty ? 16'h0000 : stack_q[rd_idx];
                  end
                  default: pc_target = 16'h0000;
               endcase
            end
         end
         HALTED: begin
            if (!halt) state_d = REQ;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         instr_q <= 16'h0000;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         sp_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WAIT) begin
            instr_q <= mem_data;
            valid_q <= 1'b1;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
         // Overflow drops the push but the call still redirects.
         if (push) begin
            if (full) err_q <= 1'b1;
            else      sp_q  <= sp_q + 1'b1;
         end
         if (pop) begin
            if (empty) err_q <= 1'b1;
            else       sp_q  <= sp_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push && !full) stack_q[wr_idx] <= pc_value;
   end
endmodule
